// File: rtl/t01_piece_pkg.sv
// rtl/t01_piece_pkg.sv - shared types and candidate helpers for the piece queue
package t01_piece_pkg;

  localparam int NUM_TYPES = 7;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_O = 3'd1,
    PIECE_T = 3'd2,
    PIECE_S = 3'd3,
    PIECE_Z = 3'd4,
    PIECE_J = 3'd5,
    PIECE_L = 3'd6
  } piece_e;

  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } state_e;

  // Low field first, then the next field; two sevens in a row fall back to I.
  function automatic logic [2:0] raw_candidate(input logic [5:0] bits);
    logic [2:0] c;
    c = bits[2:0];
    if (c == 3'd7) c = bits[5:3];
    if (c == 3'd7) c = 3'd0;
    return c;
  endfunction

  function automatic logic [2:0] bag_scan(input logic [2:0] c, input logic [6:0] used);
    logic [2:0] t;
    logic [2:0] pick;
    logic       found;
    pick  = c;
    found = 1'b0;
    t     = c;
    for (int k = 0; k < NUM_TYPES; k++) begin
      if (!found && !used[t]) begin
        pick  = t;
        found = 1'b1;
      end
      t = (t == 3'd6) ? 3'd0 : t + 3'd1;
    end
    return pick;
  endfunction

endpackage

// File: rtl/t01_lfsr.sv
// rtl/t01_lfsr.sv - free-running Fibonacci LFSR with zero guard and reseed load
module t01_lfsr #(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'd332
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reseed,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] shifted;

  assign shifted = {state[LFSR_W-2:0], ^(state & TAPS)};

  // A zero register would lock up forever, so it is replaced by SEED before it lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (reseed) begin
      state <= (seed_in != '0) ? seed_in : SEED;
    end else if (shifted == '0) begin
      state <= SEED;
    end else begin
      state <= shifted;
    end
  end

endmodule

// File: rtl/t01_piece_queue.sv
// rtl/t01_piece_queue.sv - piece randomiser with optional 7-bag and preview queue
module t01_piece_queue
  import t01_piece_pkg::*;
#(
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
  parameter logic [LFSR_W-1:0] SEED   = 16'd332,
  parameter int                DEPTH  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode_bag,
  input  logic               pop,
  input  logic               reseed,
  input  logic [LFSR_W-1:0]  seed_in,
  output logic               valid,
  output logic [2:0]         next_type,
  output logic [3*DEPTH-1:0] queue_flat,
  output logic [LFSR_W-1:0]  lfsr_state
);

  localparam int              CW   = $clog2(DEPTH);
  localparam logic [CW-1:0]   LAST = CW'(DEPTH - 1);

  state_e        state, state_nxt;
  logic [CW-1:0] fill_cnt;
  logic [6:0]    used;
  logic [6:0]    used_set;
  logic [2:0]    q [DEPTH];
  logic [2:0]    raw_c;
  logic [2:0]    cand;
  logic          wr_fill;
  logic          do_shift;
  logic          issue;

  t01_lfsr #(
    .LFSR_W (LFSR_W),
    .TAPS   (TAPS),
    .SEED   (SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .reseed  (reseed),
    .seed_in (seed_in),
    .state   (lfsr_state)
  );

  assign raw_c    = raw_candidate(lfsr_state[5:0]);
  assign cand     = mode_bag ? bag_scan(raw_c, used) : raw_c;
  assign used_set = used | (7'd1 << cand);
  assign issue    = wr_fill | do_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_fill   = 1'b0;
    do_shift  = 1'b0;
    if (reseed) begin
      state_nxt = FILL;
    end else begin
      case (state)
        FILL: begin
          wr_fill = 1'b1;
          if (fill_cnt == LAST) state_nxt = READY;
        end
        READY: begin
          if (pop) do_shift = 1'b1;
        end
        default: state_nxt = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt <= '0;
      used     <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= 3'd0;
    end else if (reseed) begin
      fill_cnt <= '0;
      used     <= '0;
      for (int i = 0; i < DEPTH; i++) q[i] <= 3'd0;
    end else begin
      if (wr_fill) begin
        q[fill_cnt] <= cand;
        if (fill_cnt != LAST) fill_cnt <= fill_cnt + 1'b1;
      end
      if (do_shift) begin
        for (int i = 0; i < DEPTH - 1; i++) q[i] <= q[i+1];
        q[DEPTH-1] <= cand;
      end
      // A full bag empties on the same edge that issues its seventh piece.
      if (!mode_bag) begin
        used <= '0;
      end else if (issue) begin
        used <= (used_set == 7'h7F) ? 7'h00 : used_set;
      end
    end
  end

  assign valid     = (state == READY);
  assign next_type = q[0];

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign queue_flat[3*g +: 3] = q[g];
  end

endmodule

// File: tb/tb_t01_piece_queue.sv
// tb/tb_t01_piece_queue.sv - directed self-checking bench for t01_piece_queue
module tb_t01_piece_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode_bag;
  logic        pop;
  logic        reseed;
  logic [15:0] seed_in;
  logic        valid;
  logic [2:0]  next_type;
  logic [8:0]  queue_flat;
  logic [15:0] lfsr_state;

  logic        reseed2;
  logic [15:0] seed_in2;
  logic        mode_bag2;
  logic        pop2;
  logic        valid2;
  logic [2:0]  next_type2;
  logic [8:0]  queue_flat2;
  logic [15:0] lfsr_state2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  t01_piece_queue #(
    .LFSR_W (16),
    .TAPS   (16'hB400),
    .SEED   (16'd332),
    .DEPTH  (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_bag   (mode_bag),
    .pop        (pop),
    .reseed     (reseed),
    .seed_in    (seed_in),
    .valid      (valid),
    .next_type  (next_type),
    .queue_flat (queue_flat),
    .lfsr_state (lfsr_state)
  );

  t01_piece_queue #(
    .LFSR_W (16),
    .TAPS   (16'h3400),
    .SEED   (16'd332),
    .DEPTH  (3)
  ) dut_zero (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_bag   (mode_bag2),
    .pop        (pop2),
    .reseed     (reseed2),
    .seed_in    (seed_in2),
    .valid      (valid2),
    .next_type  (next_type2),
    .queue_flat (queue_flat2),
    .lfsr_state (lfsr_state2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] exp_lfsr [3];
    logic        exp_valid [3];
    exp_lfsr  = '{16'h0298, 16'h0530, 16'h0A61};
    exp_valid = '{1'b0, 1'b0, 1'b1};
    rst_n = 1'b0; mode_bag = 1'b0; pop = 1'b0; reseed = 1'b0; seed_in = 16'h0;
    tick(); tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %0b want 0", valid); end
    tests++; if (queue_flat !== 9'h000) begin fails++; $display("FAIL reset_queue got %h want 000", queue_flat); end
    tests++; if (next_type !== 3'd0) begin fails++; $display("FAIL reset_next got %0d want 0", next_type); end
    tests++; if (lfsr_state !== 16'h014C) begin fails++; $display("FAIL reset_lfsr got %h want 014c", lfsr_state); end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (lfsr_state !== exp_lfsr[i]) begin fails++; $display("FAIL fill_lfsr edge %0d got %h want %h", i+1, lfsr_state, exp_lfsr[i]); end
      tests++; if (valid !== exp_valid[i]) begin fails++; $display("FAIL fill_valid edge %0d got %0b want %0b", i+1, valid, exp_valid[i]); end
      tests++; if (next_type !== 3'd4) begin fails++; $display("FAIL fill_head edge %0d got %0d want 4", i+1, next_type); end
    end
    tests++; if (queue_flat !== 9'h004) begin fails++; $display("FAIL raw_fill_queue got %h want 004", queue_flat); end
  endtask

  task automatic test_bag_fill();
    rst_n = 1'b0; mode_bag = 1'b1;
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL bag_fill_valid got %0b want 1", valid); end
    tests++; if (queue_flat !== 9'h044) begin fails++; $display("FAIL bag_fill_queue got %h want 044", queue_flat); end
  endtask

  task automatic test_bag_pops();
    int         issued [$];
    logic [8:0] old;
    logic [6:0] mask;
    issued.push_back(int'(queue_flat[2:0]));
    issued.push_back(int'(queue_flat[5:3]));
    issued.push_back(int'(queue_flat[8:6]));
    pop = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      old = queue_flat;
      tick();
      tests++; if (next_type !== old[5:3]) begin fails++; $display("FAIL bag_pop_head pop %0d got %0d want %0d", k, next_type, old[5:3]); end
      issued.push_back(int'(queue_flat[8:6]));
      if ((3 + k) % 7 == 0) begin
        tests++; if (dut.used !== 7'h00) begin fails++; $display("FAIL bag_used_clear pop %0d got %h want 00", k, dut.used); end
      end
    end
    pop = 1'b0;
    for (int g = 0; g < 10; g++) begin
      mask = 7'h00;
      for (int j = 0; j < 7; j++) mask = mask | (7'd1 << issued[7*g + j]);
      tests++; if (mask !== 7'h7F) begin fails++; $display("FAIL bag_perm group %0d got %h want 7f", g, mask); end
    end
    mode_bag = 1'b0;
  endtask

  task automatic test_hold();
    logic [8:0]  hold;
    logic [15:0] prev;
    pop = 1'b0;
    hold = queue_flat;
    prev = lfsr_state;
    for (int i = 0; i < 20; i++) begin
      tick();
      tests++; if (queue_flat !== hold) begin fails++; $display("FAIL hold_queue cycle %0d got %h want %h", i, queue_flat, hold); end
      tests++; if (lfsr_state === prev) begin fails++; $display("FAIL hold_lfsr_moves cycle %0d got %h want not %h", i, lfsr_state, prev); end
      prev = lfsr_state;
    end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    tests++; if (next_type !== hold[5:3]) begin fails++; $display("FAIL hold_pop_head got %0d want %0d", next_type, hold[5:3]); end
    tests++; if (queue_flat[5:3] !== hold[8:6]) begin fails++; $display("FAIL hold_pop_q1 got %0d want %0d", queue_flat[5:3], hold[8:6]); end
  endtask

  task automatic test_reseed_pop();
    mode_bag = 1'b0;
    reseed = 1'b1; seed_in = 16'h0000; pop = 1'b1;
    tick();
    reseed = 1'b0; pop = 1'b0;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL reseed_valid got %0b want 0", valid); end
    tests++; if (lfsr_state !== 16'h014C) begin fails++; $display("FAIL reseed_lfsr got %h want 014c", lfsr_state); end
    tests++; if (queue_flat !== 9'h000) begin fails++; $display("FAIL reseed_queue got %h want 000", queue_flat); end
    tick(); tick();
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL refill_early_valid got %0b want 0", valid); end
    tick();
    tests++; if (valid !== 1'b1) begin fails++; $display("FAIL refill_valid got %0b want 1", valid); end
    tests++; if (queue_flat !== 9'h004) begin fails++; $display("FAIL refill_queue got %h want 004", queue_flat); end
  endtask

  task automatic test_reseed_seeds();
    logic [15:0] seeds [2];
    logic [8:0]  exp_q [2];
    seeds = '{16'h00FF, 16'h0017};
    exp_q = '{9'h130, 9'h132};
    for (int s = 0; s < 2; s++) begin
      reseed = 1'b1; seed_in = seeds[s];
      tick();
      reseed = 1'b0;
      tests++; if (lfsr_state !== seeds[s]) begin fails++; $display("FAIL seed_load %0d got %h want %h", s, lfsr_state, seeds[s]); end
      tick(); tick(); tick();
      tests++; if (valid !== 1'b1) begin fails++; $display("FAIL seed_valid %0d got %0b want 1", s, valid); end
      tests++; if (queue_flat !== exp_q[s]) begin fails++; $display("FAIL seed_queue %0d got %h want %h", s, queue_flat, exp_q[s]); end
    end
  endtask

  task automatic test_zero_guard();
    reseed2 = 1'b1; seed_in2 = 16'h8000;
    tick();
    reseed2 = 1'b0;
    tests++; if (lfsr_state2 !== 16'h8000) begin fails++; $display("FAIL zero_pre got %h want 8000", lfsr_state2); end
    tick();
    tests++; if (lfsr_state2 !== 16'h014C) begin fails++; $display("FAIL zero_reload got %h want 014c", lfsr_state2); end
    for (int i = 0; i < 30; i++) begin
      tick();
      tests++; if (lfsr_state2 === 16'h0000) begin fails++; $display("FAIL zero_never cycle %0d got 0000 want nonzero", i); end
    end
  endtask

  task automatic test_reset_mid_fill();
    reseed = 1'b1; seed_in = 16'h0000;
    tick();
    reseed = 1'b0;
    tick();
    tests++; if (queue_flat !== 9'h004) begin fails++; $display("FAIL midfill_pre got %h want 004", queue_flat); end
    rst_n = 1'b0;
    #1;
    tests++; if (valid !== 1'b0) begin fails++; $display("FAIL midfill_valid got %0b want 0", valid); end
    tests++; if (queue_flat !== 9'h000) begin fails++; $display("FAIL midfill_queue got %h want 000", queue_flat); end
    tests++; if (lfsr_state !== 16'h014C) begin fails++; $display("FAIL midfill_lfsr got %h want 014c", lfsr_state); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mode_bag = 1'b0; pop = 1'b0; reseed = 1'b0; seed_in = 16'h0;
    reseed2 = 1'b0; seed_in2 = 16'h0; mode_bag2 = 1'b0; pop2 = 1'b0;
    test_reset();
    test_bag_fill();
    test_bag_pops();
    test_hold();
    test_reseed_pop();
    test_reseed_seeds();
    test_zero_guard();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/t01_piece_queue.md
# t01_piece_queue

Parametrised successor to the team's single-register block randomiser. It combines a configurable Fibonacci LFSR with an optional 7-bag randomiser and a DEPTH-entry preview queue with a pop handshake. It sits between the game FSM, which pops the next piece on spawn, and the display path, which renders the preview window. Runtime reseed and a zero-lock guard are features the previous block does not have.

## Interface
- LFSR_W, 16: LFSR width, at least 6.
- TAPS, 16'hB400: feedback mask; bit i set means lfsr[i] is XORed into feedback. The default selects bits 15, 13, 12, 10.
- SEED, 16'd332: reset and fallback seed, LFSR_W wide, must be nonzero.
- DEPTH, 3: queue entries, at least 2.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mode_bag  in  1  1 = 7-bag generation, 0 = raw LFSR generation.
- pop  in  1  consume the head piece; honoured only while valid=1.
- reseed  in  1  load seed_in, flush the queue and refill.
- seed_in  in  LFSR_W  new seed; 0 means use SEED.
- valid  out  1  queue full, head piece available.
- next_type  out  3  head piece, q[0].
- queue_flat  out  3*DEPTH  all entries; q[i] is at bits [3i+2:3i].
- lfsr_state  out  LFSR_W  current LFSR register.

## Operation
- **LFSR.** Free-running, advances every cycle. Update: lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}. If the next value would be all-zero, load SEED instead.
- **Raw candidate.** c = lfsr[2:0]. If c == 7, c = lfsr[5:3]. If that is also 7, c = 0.
- **Bag candidate.**
  - used[6:0] tracks the types already issued in the current bag.
  - The result is the first type t with used[t]=0, scanning c, c+1, …, wrapping mod 7. This is one cycle and fully combinational.
  - Issuing a piece sets used[t]. If that fills all 7 bits, used is cleared to 0 on the same edge.
  - When mode_bag=0, used is held at 0. A switch of mode_bag takes effect on the next generation.
- **FSM, state FILL.**
  - Each cycle, write the candidate to q[fill_cnt] and increment fill_cnt.
  - When fill_cnt reaches DEPTH-1 and that entry is written, move to READY and set valid=1.
  - pop is ignored in FILL.
- **FSM, state READY.**
  - On pop: q[i] <= q[i+1] for i < DEPTH-1, and q[DEPTH-1] <= candidate, all on one edge.
  - valid stays 1. Without pop, the queue holds.
- **Reseed.**
  - Takes effect in any state.
  - lfsr <= (seed_in != 0) ? seed_in : SEED. q is cleared to 0, used to 0, fill_cnt to 0, valid to 0, and the FSM goes to FILL.
  - The candidate is not written that cycle.
- **Priority.** Reseed beats pop in the same cycle, and that pop is dropped.
- **Reset values.** lfsr=SEED, q=all 0, used=0, fill_cnt=0, valid=0, state FILL, next_type=0, queue_flat=0.

## Timing
- All outputs are registered; no combinational path from input to output.
- After rst_n deasserts, FILL writes on edges 1..DEPTH. valid is 1 after edge DEPTH.
- The candidate for a given edge is computed from the pre-edge lfsr value; the LFSR advances on that same edge.
- Pop latency: next_type shows the new head one cycle after the pop edge. Back-to-back pops are allowed every cycle.
- Reseed: valid drops on the next edge and returns DEPTH edges after reseed is deasserted.
- An rst_n assertion mid-FILL or mid-pop returns all state to reset values immediately.

## Structure
- Package t01_piece_pkg:
  - piece enum, 3 bits: I=0, O=1, T=2, S=3, Z=4, J=5, L=6.
  - NUM_TYPES=7.
  - State enum {FILL, READY}.
  - Raw candidate function.
  - Bag-scan function.
- Sub-module t01_lfsr, parametrised by LFSR_W, TAPS and SEED. It covers shift, zero guard and reseed load.
- The top level holds the FSM, the bag mask and the queue shift register.

## Test plan
- Reset with defaults, mode_bag=0 → on edges 1–3 the LFSR steps 0x014C→0x0298→0x0530 and queue q[0..2] = 4, 0, 0. valid=1 after edge 3, lfsr_state=0x0A61.
- Same as above with mode_bag=1 → queue = 4, 0, 1, since candidate 0 on edge 3 is already used and the scan moves to 1.
- mode_bag=1, pop every cycle for 70 pops → each consecutive aligned group of 7 issued pieces (fill included) is a permutation of 0–6. used returns to 0 after each seventh piece.
- Queue full, pop=0 for 20 cycles → queue_flat is constant while lfsr_state changes every cycle. Then one pop → next_type = the old q[1] on the next cycle.
- reseed=1 with seed_in=0 and pop=1 in the same cycle → pop dropped, valid=0, lfsr_state=0x014C. The queue refills to 4, 0, 0 (raw mode) three edges after reseed falls.
- Force the LFSR to 0 via reseed with SEED-equivalent masking off (seed_in=0) and by a TAPS-induced zero step → lfsr_state never reads 0 and reloads to SEED. Assert rst_n low mid-FILL → valid=0 and q=0 immediately.
